// File: rtl/freq_div_ctrl_pkg.sv
// Shared definitions for the clock-divider sequencing controller: ratio bus width and FSM states.
package freq_div_ctrl_pkg;

  localparam int FDC_SIZE = 8;

  typedef enum logic [2:0] {
    FDC_IDLE  = 3'd0,
    FDC_LOAD  = 3'd1,
    FDC_START = 3'd2,
    FDC_RUN   = 3'd3,
    FDC_DRAIN = 3'd4
  } fdc_state_t;

  // States in which the divided output is live and completed periods are meaningful.
  function automatic logic fdc_counting(input fdc_state_t s);
    return (s == FDC_RUN) || (s == FDC_DRAIN);
  endfunction

endpackage

// File: rtl/div_period_tracker.sv
// Shadow of the datapath counter: flags the last input cycle of each output period.
// FREQ_DIV_CTRL_PERIOD_CNT_EN adds a wrapping count of completed periods.
module div_period_tracker
  import freq_div_ctrl_pkg::*;
#(
  parameter int SIZE = FDC_SIZE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            count_en,
  input  logic [SIZE-1:0] ratio,
`ifdef FREQ_DIV_CTRL_PERIOD_CNT_EN
  input  logic            period_clear,
  input  logic            period_inc_en,
  output logic [SIZE-1:0] period_cnt,
`endif
  output logic            period_end
);

  logic [SIZE-1:0] cnt;
  logic [SIZE-1:0] last;

  // ratio==1 gives last==0, so every cycle is a period end.
  assign last       = ratio - SIZE'(1);
  assign period_end = (cnt == last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count_en) begin
      cnt <= period_end ? '0 : cnt + SIZE'(1);
    end
  end

`ifdef FREQ_DIV_CTRL_PERIOD_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_cnt <= '0;
    end else if (period_clear) begin
      period_cnt <= '0;
    end else if (period_inc_en && period_end) begin
      period_cnt <= period_cnt + SIZE'(1);
    end
  end
`endif

endmodule

// File: rtl/freq_div_ctrl.sv
// Sequencing controller for the programmable clock divider; ratio changes land only on period boundaries.
// Optional feature macro: FREQ_DIV_CTRL_PERIOD_CNT_EN (adds period_cnt output).
module freq_div_ctrl
  import freq_div_ctrl_pkg::*;
#(
  parameter int SIZE = FDC_SIZE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic [SIZE-1:0] req_p,
  output logic            req_ready,
  output logic [SIZE-1:0] p_out,
  output logic            sel_odd,
  output logic            not_zero,
  output logic            enable,
  output logic            div_reset,
`ifdef FREQ_DIV_CTRL_PERIOD_CNT_EN
  output logic [SIZE-1:0] period_cnt,
`endif
  output logic            busy
);

  fdc_state_t      state;
  logic [SIZE-1:0] pend_p;
  logic [SIZE-1:0] load_p;
  logic            accept;
  logic            go_load;
  logic            period_end;

  assign accept = req_valid & req_ready;

  // A request accepted in IDLE loads straight from the bus; from DRAIN it comes from pend_p.
  always_comb begin
    load_p  = pend_p;
    go_load = 1'b0;
    case (state)
      FDC_IDLE: begin
        if (accept && (req_p != '0)) begin
          load_p  = req_p;
          go_load = 1'b1;
        end
      end
      FDC_DRAIN: begin
        if (period_end && (pend_p != '0)) begin
          go_load = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FDC_IDLE;
      pend_p    <= '0;
      p_out     <= '0;
      sel_odd   <= 1'b0;
      not_zero  <= 1'b0;
      enable    <= 1'b0;
      div_reset <= 1'b1;
      busy      <= 1'b0;
      req_ready <= 1'b0;
    end else if (go_load) begin
      state     <= FDC_LOAD;
      pend_p    <= load_p;
      p_out     <= load_p;
      sel_odd   <= load_p[0];
      not_zero  <= (load_p > SIZE'(1));
      div_reset <= 1'b1;
      enable    <= 1'b0;
      busy      <= 1'b1;
      req_ready <= 1'b0;
    end else begin
      case (state)
        FDC_IDLE: begin
          div_reset <= 1'b0;
          enable    <= 1'b0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
        FDC_LOAD: begin
          state     <= FDC_START;
          div_reset <= 1'b0;
          enable    <= 1'b1;
        end
        FDC_START: begin
          state     <= FDC_RUN;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
        FDC_RUN: begin
          // Re-requesting the current ratio is acknowledged without disturbing the datapath.
          if (accept && (req_p != p_out)) begin
            state     <= FDC_DRAIN;
            pend_p    <= req_p;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        FDC_DRAIN: begin
          if (period_end) begin
            state     <= FDC_IDLE;
            enable    <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= FDC_IDLE;
      endcase
    end
  end

  div_period_tracker #(
    .SIZE(SIZE)
  ) u_tracker (
    .clk           (clk),
    .reset         (reset),
    .clear         (state == FDC_START),
    .count_en      (enable),
    .ratio         (p_out),
`ifdef FREQ_DIV_CTRL_PERIOD_CNT_EN
    .period_clear  (state == FDC_LOAD),
    .period_inc_en (fdc_counting(state)),
    .period_cnt    (period_cnt),
`endif
    .period_end    (period_end)
  );

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Directed self-checking bench for freq_div_ctrl; expected values are hand-derived per step.
module tb_freq_div_ctrl;

  localparam int SIZE = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid;
  logic [SIZE-1:0] req_p;
  logic            req_ready;
  logic [SIZE-1:0] p_out;
  logic            sel_odd;
  logic            not_zero;
  logic            enable;
  logic            div_reset;
  logic            busy;
`ifdef FREQ_DIV_CTRL_PERIOD_CNT_EN
  logic [SIZE-1:0] period_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  freq_div_ctrl #(.SIZE(SIZE)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_p     (req_p),
    .req_ready (req_ready),
    .p_out     (p_out),
    .sel_odd   (sel_odd),
    .not_zero  (not_zero),
    .enable    (enable),
    .div_reset (div_reset),
`ifdef FREQ_DIV_CTRL_PERIOD_CNT_EN
    .period_cnt(period_cnt),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input int p, input bit so, input bit nz,
                         input bit en, input bit dr, input bit bz, input bit rr);
    chk({tag, ".p_out"},     32'(p_out),     32'(p));
    chk({tag, ".sel_odd"},   32'(sel_odd),   32'(so));
    chk({tag, ".not_zero"},  32'(not_zero),  32'(nz));
    chk({tag, ".enable"},    32'(enable),    32'(en));
    chk({tag, ".div_reset"}, 32'(div_reset), 32'(dr));
    chk({tag, ".busy"},      32'(busy),      32'(bz));
    chk({tag, ".req_ready"}, 32'(req_ready), 32'(rr));
    $display("step %-12s p_out=%0d sel_odd=%0b not_zero=%0b enable=%0b div_reset=%0b busy=%0b req_ready=%0b",
             tag, p_out, sel_odd, not_zero, enable, div_reset, busy, req_ready);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_p = '0;
    #2;
    chk_all("rst_async", 0, 0, 0, 0, 1, 0, 0);
    tick(); tick();
    chk_all("rst_held", 0, 0, 0, 0, 1, 0, 0);
    reset = 1'b0;
    tick();
    chk_all("idle", 0, 0, 0, 0, 0, 0, 1);

    // 1: ratio 4 from IDLE
    req_valid = 1'b1; req_p = 8'd4;
    tick(); chk_all("t1_load", 4, 0, 1, 0, 1, 1, 0);
    req_valid = 1'b0;
    tick(); chk_all("t1_start", 4, 0, 1, 1, 0, 1, 0);
    tick(); chk_all("t1_run", 4, 0, 1, 1, 0, 0, 1);

    // 2: request 5 at cnt=1; a different value offered during DRAIN must be ignored
    tick();
    req_valid = 1'b1; req_p = 8'd5;
    tick(); chk_all("t2_drain1", 4, 0, 1, 1, 0, 1, 0);
    req_p = 8'd9;
    tick(); chk_all("t2_drain2", 4, 0, 1, 1, 0, 1, 0);
    tick(); chk_all("t2_load", 5, 1, 1, 0, 1, 1, 0);
    req_valid = 1'b0;
    tick(); tick(); chk_all("t2_run", 5, 1, 1, 1, 0, 0, 1);

    // move to 6, accepted at cnt=0: four DRAIN cycles
    req_valid = 1'b1; req_p = 8'd6;
    tick(); req_valid = 1'b0;
    repeat (3) tick();
    chk_all("to6_drain4", 5, 1, 1, 1, 0, 1, 0);
    tick(); chk_all("to6_load", 6, 0, 1, 0, 1, 1, 0);
    tick(); tick();

    // 3: bypass, then 3 quickly
    req_valid = 1'b1; req_p = 8'd1;
    tick(); req_valid = 1'b0;
    repeat (4) tick();
    chk_all("t3_drain5", 6, 0, 1, 1, 0, 1, 0);
    tick(); chk_all("t3_load1", 1, 1, 0, 0, 1, 1, 0);
    tick(); tick(); chk_all("t3_run1", 1, 1, 0, 1, 0, 0, 1);
    req_valid = 1'b1; req_p = 8'd3;
    tick(); req_valid = 1'b0;
    chk_all("t3_drain", 1, 1, 0, 1, 0, 1, 0);
    tick(); chk_all("t3_load3", 3, 1, 1, 0, 1, 1, 0);
    tick(); tick();

    // 4: stop at ratio 3
    req_valid = 1'b1; req_p = 8'd0;
    tick(); req_valid = 1'b0;
    chk_all("t4_drain1", 3, 1, 1, 1, 0, 1, 0);
    tick(); chk_all("t4_drain2", 3, 1, 1, 1, 0, 1, 0);
    tick(); chk_all("t4_idle", 3, 1, 1, 0, 0, 0, 1);
    req_valid = 1'b1; req_p = 8'd0;
    tick(); chk_all("t4_idle_p0", 3, 1, 1, 0, 0, 0, 1);
    req_valid = 1'b0;

    // 5: same-ratio request is a no-op ack
    req_valid = 1'b1; req_p = 8'd7;
    tick(); chk_all("t5_load", 7, 1, 1, 0, 1, 1, 0);
    tick(); tick(); chk_all("t5_run", 7, 1, 1, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick(); chk_all("t5_ack", 7, 1, 1, 1, 0, 0, 1);
    end
    req_valid = 1'b0;

    // 6: reset during DRAIN
    req_valid = 1'b1; req_p = 8'd2;
    tick(); req_valid = 1'b0;
    chk_all("t6_drain", 7, 1, 1, 1, 0, 1, 0);
    reset = 1'b1;
    #1;
    chk_all("t6_rst", 0, 0, 0, 0, 1, 0, 0);
    tick();
    reset = 1'b0;
    tick(); chk_all("t6_idle", 0, 0, 0, 0, 0, 0, 1);
    repeat (3) tick();
    chk_all("t6_no_stale", 0, 0, 0, 0, 0, 0, 1);

`ifdef FREQ_DIV_CTRL_PERIOD_CNT_EN
    req_valid = 1'b1; req_p = 8'd2;
    tick(); req_valid = 1'b0;
    tick(); chk("pc_start", 32'(period_cnt), 32'd0);
    tick();
    repeat (10) tick();
    chk("pc_after10", 32'(period_cnt), 32'd5);
    $display("step pc_after10   period_cnt=%0d", period_cnt);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
